sliding_bevel_block: RTL and testbench

- Stateful successor to the static and movable bevelled blocks. The block owns its own position registers.
- It accepts move commands over a valid/ready handshake and animates each move smoothly, STEP pixels per frame tick.
- It renders a bevelled sprite of parameterised size and bevel depth, with optional flashing, and produces a registered color_t for the current (col,row).
- It sits in the tetris display path, between the game controller (move commands) and the color mux feeding the VGA palette.

---
 rtl/sliding_bevel_block.sv | 214 +++++++++++++++++++++
 tb/tb_sliding_bevel_block.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sliding_bevel_block.sv
// Sliding bevelled sprite: owns its position, animates validated move
// commands at STEP pixels per frame and renders a registered bevelled color.

package sliding_bevel_block_pkg;
    typedef logic [3:0] color_t;
    localparam color_t COLOR_NONE = 4'd0;
    localparam color_t COLOR_BLUE = 4'd1;
endpackage

module sliding_bevel_block
    import sliding_bevel_block_pkg::*;
#(
    parameter color_t      COLOR       = COLOR_BLUE,
    parameter int unsigned CELL_W      = 16,
    parameter int unsigned CELL_H      = 16,
    parameter int unsigned BEVEL       = 3,
    parameter int unsigned STEP        = 4,
    parameter int unsigned MIN_X       = 120,
    parameter int unsigned MAX_X       = 280,
    parameter int unsigned MAX_Y       = 400,
    parameter int unsigned INIT_X      = 200,
    parameter int unsigned INIT_Y      = 16,
    parameter int unsigned FLASH_TICKS = 8,
    parameter int unsigned BUS_WIDTH   = 11
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] col,
    input  logic [BUS_WIDTH-1:0] row,
    input  logic                 frame_tick,
    input  logic                 move_valid,
    input  logic [1:0]           move_dir,
    output logic                 move_ready,
    output logic                 move_reject,
    input  logic                 flash_en,
    output logic [BUS_WIDTH-1:0] x_pos,
    output logic [BUS_WIDTH-1:0] y_pos,
    output logic                 busy,
    output color_t               color
);

    localparam int unsigned BW = BUS_WIDTH;
    // One extra bit so bound checks on x+CELL_W etc. cannot wrap.
    localparam int unsigned WW = BUS_WIDTH + 1;
    localparam int unsigned FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;

    typedef enum logic {
        IDLE,
        SLIDE
    } state_t;

    state_t          state;
    logic [BW-1:0]   tgt;
    logic            axis_y;
    logic [FW-1:0]   flash_cnt;
    logic            flash_hidden;

    logic            cmd_illegal_c;
    logic            cmd_axis_y_c;
    logic [BW-1:0]   cmd_tgt_c;
    logic [BW-1:0]   pos_c;
    logic [BW-1:0]   step_pos_c;
    logic            inside_c;
    int unsigned     dx_c;
    int unsigned     dy_c;
    color_t          shade_c;
    logic            found_c;

    // Decode the offered command into a target and check it against the bounds.
    always_comb begin
        cmd_illegal_c = 1'b0;
        cmd_axis_y_c  = 1'b0;
        cmd_tgt_c     = x_pos;
        case (move_dir)
            2'b00: begin
                cmd_illegal_c = WW'(x_pos) < WW'(MIN_X + CELL_W);
                cmd_tgt_c     = x_pos - BW'(CELL_W);
            end
            2'b01: begin
                cmd_illegal_c = (WW'(x_pos) + WW'(CELL_W)) > WW'(MAX_X);
                cmd_tgt_c     = x_pos + BW'(CELL_W);
            end
            2'b10: begin
                cmd_axis_y_c  = 1'b1;
                cmd_illegal_c = (WW'(y_pos) + WW'(CELL_H)) > WW'(MAX_Y);
                cmd_tgt_c     = y_pos + BW'(CELL_H);
            end
            default: begin
                cmd_axis_y_c  = 1'b1;
                cmd_illegal_c = WW'(y_pos) >= WW'(MAX_Y);
                cmd_tgt_c     = BW'(MAX_Y);
            end
        endcase
    end

    // Next position on the active axis: STEP toward the target, clamped at it.
    always_comb begin
        pos_c      = axis_y ? y_pos : x_pos;
        step_pos_c = tgt;
        if (pos_c < tgt) begin
            if ((tgt - pos_c) > BW'(STEP)) begin
                step_pos_c = pos_c + BW'(STEP);
            end
        end else begin
            if ((pos_c - tgt) > BW'(STEP)) begin
                step_pos_c = pos_c - BW'(STEP);
            end
        end
    end

    // Move FSM: accept/reject commands in IDLE, animate in SLIDE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            x_pos       <= BW'(INIT_X);
            y_pos       <= BW'(INIT_Y);
            tgt         <= '0;
            axis_y      <= 1'b0;
            move_ready  <= 1'b1;
            move_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            move_reject <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (move_valid) begin
                        if (cmd_illegal_c) begin
                            move_reject <= 1'b1;
                        end else begin
                            tgt        <= cmd_tgt_c;
                            axis_y     <= cmd_axis_y_c;
                            state      <= SLIDE;
                            move_ready <= 1'b0;
                            busy       <= 1'b1;
                        end
                    end
                end
                SLIDE: begin
                    if (frame_tick) begin
                        if (axis_y) begin
                            y_pos <= step_pos_c;
                        end else begin
                            x_pos <= step_pos_c;
                        end
                        if (step_pos_c == tgt) begin
                            state      <= IDLE;
                            move_ready <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Flash phase: toggles every FLASH_TICKS frames while enabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flash_cnt    <= '0;
            flash_hidden <= 1'b0;
        end else if (!flash_en) begin
            flash_cnt    <= '0;
            flash_hidden <= 1'b0;
        end else if (frame_tick) begin
            if (flash_cnt == FW'(FLASH_TICKS - 1)) begin
                flash_cnt    <= '0;
                flash_hidden <= ~flash_hidden;
            end else begin
                flash_cnt <= flash_cnt + FW'(1);
            end
        end
    end

    // Box test and bevel shade for the current pixel.
    always_comb begin
        inside_c = (WW'(col) >= WW'(x_pos)) &&
                   (WW'(col) <= (WW'(x_pos) + WW'(CELL_W - 1))) &&
                   (WW'(row) >= WW'(y_pos)) &&
                   (WW'(row) <= (WW'(y_pos) + WW'(CELL_H - 1)));
        dx_c     = 32'(WW'(col) - WW'(x_pos));
        dy_c     = 32'(WW'(row) - WW'(y_pos));
        shade_c  = COLOR;
        found_c  = 1'b0;
        for (int unsigned k = 0; k < BEVEL; k++) begin
            if (!found_c) begin
                if (dy_c == k && dx_c >= k && dx_c <= CELL_W - 2 - k) begin
                    shade_c = color_t'(COLOR + 4'd1);
                    found_c = 1'b1;
                end else if (dy_c == CELL_H - 1 - k && dx_c >= k + 1 && dx_c <= CELL_W - 1 - k) begin
                    shade_c = color_t'(COLOR + 4'd2);
                    found_c = 1'b1;
                end else if (dx_c == k && dy_c >= k + 1 && dy_c <= CELL_H - 1 - k) begin
                    shade_c = color_t'(COLOR + 4'd3);
                    found_c = 1'b1;
                end else if (dx_c == CELL_W - 1 - k && dy_c >= k && dy_c <= CELL_H - 2 - k) begin
                    shade_c = color_t'(COLOR + 4'd4);
                    found_c = 1'b1;
                end
            end
        end
    end

    // Registered pixel color; a disabled flash is visible immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            color <= COLOR_NONE;
        end else if (inside_c && !(flash_hidden && flash_en)) begin
            color <= shade_c;
        end else begin
            color <= COLOR_NONE;
        end
    end

endmodule

// File: tb/tb_sliding_bevel_block.sv
// Randomised and directed bench for sliding_bevel_block against a ring-based
// behavioural model of position, handshake, flash and bevel rendering.

module tb_sliding_bevel_block;
    import sliding_bevel_block_pkg::*;

    localparam int BW     = 11;
    localparam int CW     = 16;
    localparam int CH     = 16;
    localparam int BEV    = 3;
    localparam int STEP   = 4;
    localparam int MIN_X  = 120;
    localparam int MAX_X  = 280;
    localparam int MAX_Y  = 400;
    localparam int INIT_X = 200;
    localparam int INIT_Y = 16;
    localparam int FT     = 8;
    localparam color_t C  = COLOR_BLUE;

    logic          clock = 1'b0;
    logic          reset;
    logic [BW-1:0] col;
    logic [BW-1:0] row;
    logic          frame_tick;
    logic          move_valid;
    logic [1:0]    move_dir;
    logic          move_ready;
    logic          move_reject;
    logic          flash_en;
    logic [BW-1:0] x_pos;
    logic [BW-1:0] y_pos;
    logic          busy;
    color_t        color;

    int checks   = 0;
    int failures = 0;

    // Model state
    int     mx, my, mtgt, mcnt;
    bit     maxis_y, msliding, mreject, mhidden;
    color_t mcolor;

    sliding_bevel_block dut (
        .clock      (clock),
        .reset      (reset),
        .col        (col),
        .row        (row),
        .frame_tick (frame_tick),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .move_reject(move_reject),
        .flash_en   (flash_en),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .busy       (busy),
        .color      (color)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pixel color from concentric rings: depth d = distance to nearest edge.
    function automatic color_t model_pixel(input int c, input int r, input int x, input int y,
                                           input bit hide);
        int dx, dy, d;
        dx = c - x;
        dy = r - y;
        if (hide || dx < 0 || dy < 0 || dx > CW - 1 || dy > CH - 1) return COLOR_NONE;
        d = dx;
        if (dy < d) d = dy;
        if (CW - 1 - dx < d) d = CW - 1 - dx;
        if (CH - 1 - dy < d) d = CH - 1 - dy;
        if (d >= BEV) return C;
        if (dy == d && dx < CW - 1 - d) return color_t'(C + 4'd1);
        if (dx == CW - 1 - d && dy < CH - 1 - d) return color_t'(C + 4'd4);
        if (dy == CH - 1 - d && dx > d) return color_t'(C + 4'd2);
        return color_t'(C + 4'd3);
    endfunction

    function automatic int toward(input int p, input int t);
        if (p < t) return (t - p <= STEP) ? t : p + STEP;
        return (p - t <= STEP) ? t : p - STEP;
    endfunction

    task automatic model_reset();
        mx = INIT_X; my = INIT_Y; mtgt = 0; maxis_y = 0;
        msliding = 0; mreject = 0; mhidden = 0; mcnt = 0;
        mcolor = COLOR_NONE;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        mcolor  = model_pixel(int'(col), int'(row), mx, my, mhidden && flash_en);
        mreject = 0;
        if (!msliding) begin
            if (move_valid) begin
                case (move_dir)
                    2'd0: if (mx - CW < MIN_X) mreject = 1;
                          else begin msliding = 1; maxis_y = 0; mtgt = mx - CW; end
                    2'd1: if (mx + CW > MAX_X) mreject = 1;
                          else begin msliding = 1; maxis_y = 0; mtgt = mx + CW; end
                    2'd2: if (my + CH > MAX_Y) mreject = 1;
                          else begin msliding = 1; maxis_y = 1; mtgt = my + CH; end
                    default: if (my == MAX_Y) mreject = 1;
                             else begin msliding = 1; maxis_y = 1; mtgt = MAX_Y; end
                endcase
            end
        end else if (frame_tick) begin
            if (maxis_y) begin
                my = toward(my, mtgt);
                if (my == mtgt) msliding = 0;
            end else begin
                mx = toward(mx, mtgt);
                if (mx == mtgt) msliding = 0;
            end
        end
        if (!flash_en) begin
            mcnt = 0; mhidden = 0;
        end else if (frame_tick) begin
            if (mcnt == FT - 1) begin mcnt = 0; mhidden = !mhidden; end
            else mcnt++;
        end
    endtask

    task automatic compare();
        check("x_pos", int'(x_pos), mx);
        check("y_pos", int'(y_pos), my);
        check("busy", int'(busy), int'(msliding));
        check("move_ready", int'(move_ready), int'(!msliding));
        check("move_reject", int'(move_reject), int'(mreject));
        check("color", int'(color), int'(mcolor));
    endtask

    // One clock: model follows the pre-edge inputs, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare();
    endtask

    task automatic pixel(input int c, input int r, input color_t exp, input string name);
        col = BW'(c);
        row = BW'(r);
        step();
        check(name, int'(color), int'(exp));
    endtask

    task automatic do_move(input logic [1:0] dir);
        int n;
        move_valid = 1'b1;
        move_dir   = dir;
        step();
        move_valid = 1'b0;
        n = 0;
        while (msliding && n < 200) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
            n++;
        end
        if (n >= 200) check("move_timeout", 1, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; col = '0; row = '0; frame_tick = 1'b0;
        move_valid = 1'b0; move_dir = 2'd0; flash_en = 1'b0;
        model_reset();
        step();
        step();
        check("rst_x", int'(x_pos), 200);
        check("rst_y", int'(y_pos), 16);
        check("rst_ready", int'(move_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_color", int'(color), int'(COLOR_NONE));
        reset = 1'b0;

        // Bevel pixels at the reset position
        pixel(200, 16, color_t'(C + 4'd1), "pix_200_16");
        pixel(215, 16, color_t'(C + 4'd4), "pix_215_16");
        pixel(200, 31, color_t'(C + 4'd3), "pix_200_31");
        pixel(207, 20, C, "pix_207_20");
        pixel(199, 16, COLOR_NONE, "pix_199_16");
        pixel(215, 31, color_t'(C + 4'd2), "pix_215_31");

        // Right move, four ticks
        move_valid = 1'b1; move_dir = 2'd1;
        step();
        move_valid = 1'b0;
        check("right_busy", int'(busy), 1);
        for (int i = 1; i <= 4; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            check("right_x", int'(x_pos), 200 + 4 * i);
            step();
        end
        check("right_busy_done", int'(busy), 0);
        check("right_ready", int'(move_ready), 1);

        // Walk to the left wall and try to pass it
        for (int i = 0; i < 6; i++) do_move(2'd0);
        check("wall_x", int'(x_pos), 120);
        move_valid = 1'b1; move_dir = 2'd0;
        step();
        move_valid = 1'b0;
        check("wall_reject", int'(move_reject), 1);
        check("wall_x_hold", int'(x_pos), 120);
        check("wall_ready", int'(move_ready), 1);
        step();
        check("wall_reject_pulse", int'(move_reject), 0);

        // Hard drop with move_valid held high throughout
        move_valid = 1'b1; move_dir = 2'd3;
        step();
        move_dir = 2'd2;
        frame_tick = 1'b1;
        n = 0;
        while (msliding && n < 300) begin
            step();
            n++;
        end
        move_valid = 1'b0;
        frame_tick = 1'b0;
        check("drop_ticks", n, 96);
        check("drop_y", int'(y_pos), 400);
        check("drop_busy", int'(busy), 0);
        step();
        check("drop_no_second", int'(busy), 0);

        reset = 1'b1;
        step();
        reset = 1'b0;

        // Flash phase inside the box
        col = BW'(207); row = BW'(21);
        flash_en = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
            check("flash_phase", int'(color), ((i / 8) % 2 == 1) ? int'(COLOR_NONE) : int'(C));
        end
        flash_en = 1'b0;
        step();
        check("flash_off", int'(color), int'(C));

        // Reset in the middle of a down slide
        move_valid = 1'b1; move_dir = 2'd2;
        step();
        move_valid = 1'b0;
        frame_tick = 1'b1;
        step();
        step();
        frame_tick = 1'b0;
        check("mid_y", int'(y_pos), 24);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_x", int'(x_pos), 200);
        check("async_y", int'(y_pos), 16);
        check("async_busy", int'(busy), 0);
        check("async_ready", int'(move_ready), 1);
        compare();
        step();
        reset = 1'b0;

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            move_valid = ($urandom_range(0, 3) == 0);
            move_dir   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) flash_en = !flash_en;
            col = BW'(mx - 2 + $urandom_range(0, CW + 3));
            row = BW'(my - 2 + $urandom_range(0, CH + 3));
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
